// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands arrive over a valid/ready handshake. The result is held on res/outValid
// until the consumer takes it.
//
// Ports:
//   clk, rstn            clock; asynchronous active-low reset
//   flush                synchronous abort; discards any in-flight or pending result
//   inValid/inReady      request handshake; op1/op2/ctrl are latched on accept
//   op1, op2             dividend and divisor (XLEN bits)
//   ctrl                 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   outValid/outReady    result handshake; res is stable while outValid=1
//   res                  quotient or remainder, selected by the latched ctrl
//   busy                 high while the unit is dividing or fixing up signs
//
// Optional feature: define DIV_UNIT_FASTPATH_EN to skip the iterative loop for
// op2==0, signed overflow and op2==1. Results are identical; only latency changes.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [1:0]      ctrl,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] res,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] quot, rem, divisor, cnt;
    logic            neg_q, neg_r, sel_rem;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    // Operand conditioning at accept time
    logic            accept_c, signed_c, a_neg_c, b_neg_c, fast_c;
    logic [XLEN-1:0] abs1_c, abs2_c;

    assign accept_c = inValid & inReady & ~flush;
    assign signed_c = ~ctrl[0];
    assign a_neg_c  = signed_c & op1[XLEN-1];
    assign b_neg_c  = signed_c & op2[XLEN-1];
    assign abs1_c   = a_neg_c ? negate(op1) : op1;
    assign abs2_c   = b_neg_c ? negate(op2) : op2;

`ifdef DIV_UNIT_FASTPATH_EN
    localparam logic [XLEN-1:0] MIN_NEG = XLEN'(1) << (XLEN - 1);
    logic            ovf_c;
    logic [XLEN-1:0] fast_q_c, fast_r_c;

    assign ovf_c    = signed_c & (op1 == MIN_NEG) & (&op2);
    assign fast_c   = (op2 == '0) | ovf_c | (op2 == XLEN'(1));
    assign fast_q_c = (op2 == '0) ? '1  : op1;
    assign fast_r_c = (op2 == '0) ? op1 : '0;
`else
    assign fast_c   = 1'b0;
`endif

    // One restoring step: shift in next dividend bit, subtract if it fits.
    // Bit XLEN of the difference is the borrow.
    logic [XLEN:0] shifted_c, diff_c;

    assign shifted_c = {rem, quot[XLEN-1]};
    assign diff_c    = shifted_c - {1'b0, divisor};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept_c) state_n = fast_c ? FIX : CALC;
            CALC:    if (cnt == '0) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    if (outValid && outReady) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // Datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            quot    <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
            res     <= '0;
        end else if (accept_c) begin
            quot    <= abs1_c;
            rem     <= '0;
            divisor <= abs2_c;
            cnt     <= XLEN'(XLEN - 1);
            // Divide by zero keeps quotient all-ones regardless of signs
            neg_q   <= (a_neg_c ^ b_neg_c) & (op2 != '0);
            neg_r   <= a_neg_c;
            sel_rem <= ctrl[1];
`ifdef DIV_UNIT_FASTPATH_EN
            // Fast path preloads the final values; FIX then only selects
            if (fast_c) begin
                quot  <= fast_q_c;
                rem   <= fast_r_c;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end
`endif
        end else if (!flush && state == CALC) begin
            cnt <= cnt - XLEN'(1);
            if (diff_c[XLEN]) begin
                rem  <= shifted_c[XLEN-1:0];
                quot <= {quot[XLEN-2:0], 1'b0};
            end else begin
                rem  <= diff_c[XLEN-1:0];
                quot <= {quot[XLEN-2:0], 1'b1};
            end
        end else if (!flush && state == FIX) begin
            if (sel_rem) res <= neg_r ? negate(rem)  : rem;
            else         res <= neg_q ? negate(quot) : quot;
        end
    end

    // Registered handshake/status outputs; outValid rises one cycle after entering DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inReady  <= 1'b1;
            outValid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            inReady  <= (state_n == IDLE);
            outValid <= (state == DONE) && (state_n == DONE);
            busy     <= (state_n == CALC) || (state_n == FIX);
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (XLEN=32).
module tb_div_unit;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;
`ifdef DIV_UNIT_FASTPATH_EN
    localparam int FLAT = 2;
`else
    localparam int FLAT = LAT;
`endif

    logic            clk = 1'b0;
    logic            rstn;
    logic            flush;
    logic            inValid;
    logic            inReady;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [1:0]      ctrl;
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] res;
    logic            busy;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] C_DIV = 2'b00, C_DIVU = 2'b01, C_REM = 2'b10, C_REMU = 2'b11;

    div_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .inValid(inValid), .inReady(inReady),
        .op1(op1), .op2(op2), .ctrl(ctrl),
        .outValid(outValid), .outReady(outReady),
        .res(res), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic wait_ready();
        int n = 0;
        while (!inReady && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!inReady) begin
            errors++; checks++;
            $display("FAIL wait_ready: inReady=%0b after %0d cycles, required 1", inReady, n);
        end
    endtask

    // Present a request for one edge, then scramble the inputs to show they are latched
    task automatic start_op(input logic [1:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        wait_ready();
        inValid = 1'b1; op1 = a; op2 = b; ctrl = c;
        @(posedge clk); #1;
        inValid = 1'b0; op1 = ~a; op2 = 32'd3; ctrl = ~c;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!outValid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [1:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input int exp_lat, input logic [XLEN-1:0] exp_res, input string name);
        int lat;
        start_op(c, a, b);
        wait_out(lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, lat, exp_lat);
        end
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s result: got 0x%08h, required 0x%08h", name, res, exp_res);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        op1 = '0; op2 = '0; ctrl = '0;
        #12;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || busy !== 1'b0 || res !== 32'h0) begin
            errors++;
            $display("FAIL reset: inReady=%0b outValid=%0b busy=%0b res=0x%08h, required 1 0 0 0x00000000",
                     inReady, outValid, busy, res);
        end
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        do_op(C_DIVU, 32'd100, 32'd7, LAT, 32'd14, "divu_100_7");
        do_op(C_REMU, 32'd100, 32'd7, LAT, 32'd2, "remu_100_7");
        do_op(C_DIV, 32'hFFFF_FFF9, 32'd2, LAT, 32'hFFFF_FFFD, "div_m7_2");
        do_op(C_REM, 32'hFFFF_FFF9, 32'd2, LAT, 32'hFFFF_FFFF, "rem_m7_2");
        do_op(C_REM, 32'd7, 32'hFFFF_FFFE, LAT, 32'd1, "rem_7_m2");
        do_op(C_DIV, 32'hFFFF_FFFA, 32'd3, LAT, 32'hFFFF_FFFE, "div_m6_3");
        do_op(C_DIVU, 32'hFFFF_FFF9, 32'd2, LAT, 32'h7FFF_FFFC, "divu_big_2");
    endtask

    task automatic test_special();
        do_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, FLAT, 32'h8000_0000, "div_ovf");
        do_op(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, FLAT, 32'h0, "rem_ovf");
        do_op(C_DIVU, 32'd5, 32'd0, FLAT, 32'hFFFF_FFFF, "divu_5_0");
        do_op(C_REMU, 32'd5, 32'd0, FLAT, 32'd5, "remu_5_0");
        do_op(C_DIV, 32'hFFFF_FFFB, 32'd0, FLAT, 32'hFFFF_FFFF, "div_m5_0");
        do_op(C_REM, 32'hFFFF_FFFB, 32'd0, FLAT, 32'hFFFF_FFFB, "rem_m5_0");
        do_op(C_DIVU, 32'hFFFF_FFFF, 32'd1, FLAT, 32'hFFFF_FFFF, "divu_by1");
    endtask

    task automatic test_hold();
        int lat;
        int bad = 0;
        start_op(C_DIVU, 32'd200, 32'd9);
        wait_out(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (outValid !== 1'b1 || res !== 32'd22 || inReady !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold: %0d unstable cycles (outValid=%0b res=0x%08h inReady=%0b), required 0",
                     bad, outValid, res, inReady);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL release: inReady=%0b outValid=%0b, required 1 0", inReady, outValid);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        start_op(C_DIVU, 32'd100, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_calc: busy=%0b, required 1", busy);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (inReady !== 1'b1 || busy !== 1'b0 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: inReady=%0b busy=%0b outValid=%0b, required 1 0 0",
                     inReady, busy, outValid);
        end
        for (int i = 0; i < LAT + 6; i++) begin
            @(posedge clk); #1;
            if (outValid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_result: outValid high %0d cycles, required 0", seen);
        end
        do_op(C_DIVU, 32'd9, 32'd3, LAT, 32'd3, "divu_9_3_after_flush");

        // flush beats a same-cycle request
        inValid = 1'b1; flush = 1'b1; op1 = 32'd9; op2 = 32'd3; ctrl = C_DIVU;
        @(posedge clk); #1;
        inValid = 1'b0; flush = 1'b0;
        checks++;
        if (inReady !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_vs_accept: inReady=%0b busy=%0b, required 1 0", inReady, busy);
        end

        // flush with outReady in DONE drops the result
        begin
            int lat;
            start_op(C_DIVU, 32'd50, 32'd5);
            wait_out(lat);
            flush = 1'b1; outReady = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0; outReady = 1'b0;
            checks++;
            if (outValid !== 1'b0 || inReady !== 1'b1) begin
                errors++;
                $display("FAIL flush_done: outValid=%0b inReady=%0b, required 0 1", outValid, inReady);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_op(C_DIVU, 32'd100, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || busy !== 1'b0 || res !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: inReady=%0b outValid=%0b busy=%0b res=0x%08h, required 1 0 0 0x00000000",
                     inReady, outValid, busy, res);
        end
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        do_op(C_REMU, 32'd100, 32'd7, LAT, 32'd2, "remu_after_reset");
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
